// File: rtl/ram2p_bist_pkg.sv
// Shared encodings for the ram2p self-test sequencer:
// FSM states and data-pattern select codes.
package ram2p_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READ  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [1:0] PAT_ADDR  = 2'd0;
    localparam logic [1:0] PAT_NADDR = 2'd1;
    localparam logic [1:0] PAT_CHK   = 2'd2;
    localparam logic [1:0] PAT_ONES  = 2'd3;

endpackage

// File: rtl/ram2p_bist_pat.sv
// Pattern generator: data word for an address under a pattern code.
// Ports: addr (word address), pattern (code), data (pattern word).
module ram2p_bist_pat
    import ram2p_bist_pkg::*;
#(
    parameter int AWID = 8,
    parameter int DWID = 16
) (
    input  logic [AWID-1:0] addr,
    input  logic [1:0]      pattern,
    output logic [DWID-1:0] data
);

    logic [DWID-1:0] a_ext;
    logic [DWID-1:0] chk;

    always_comb begin
        a_ext = DWID'(addr);
        chk   = '0;
        // Even bits follow ~addr[0], odd bits follow addr[0]:
        // 0101.. for even words, 1010.. for odd words.
        for (int i = 0; i < DWID; i++) begin
            chk[i] = (i % 2 == 0) ? ~addr[0] : addr[0];
        end
        data = '1;
        unique case (pattern)
            PAT_ADDR:  data = a_ext;
            PAT_NADDR: data = ~a_ext;
            PAT_CHK:   data = chk;
            PAT_ONES:  data = '1;
        endcase
    end

endmodule

// File: rtl/ram2p_bist.sv
// Self-test sequencer for a ram2p: fill all words, read back, compare.
// Ports: clk/rst_n, i_start/i_abort/i_pattern control, o_busy/o_done/
// o_pass/o_err_cnt/o_first_err_addr status, o_we/o_waddr/o_wdat port A,
// o_raddr/i_rdat port B.
module ram2p_bist
    import ram2p_bist_pkg::*;
#(
    parameter int AWID   = 8,
    parameter int DWID   = 16,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [1:0]      i_pattern,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [AWID:0]   o_err_cnt,
    output logic [AWID-1:0] o_first_err_addr,
    output logic            o_we,
    output logic [AWID-1:0] o_waddr,
    output logic [DWID-1:0] o_wdat,
    output logic [AWID-1:0] o_raddr,
    input  logic [DWID-1:0] i_rdat
);

    localparam int              DEPTH   = 2 ** AWID;
    localparam logic [AWID-1:0] LAST    = AWID'(DEPTH - 1);
    localparam logic [2:0]      FL_LAST = 3'(RD_LAT);
    localparam logic [AWID:0]   ERR_MAX = '1;

    state_t          st_q, st_d;
    logic [1:0]      pat_q, pat_d;
    logic [2:0]      fl_q, fl_d;
    logic            busy_d, done_d, pass_d, we_d;
    logic            issue, flush, cmp;
    logic [AWID-1:0] waddr_d, raddr_d, first_d;
    logic [AWID:0]   err_d;
    logic [DWID-1:0] wdat_d, exp_d;

    // Read delay line: entry 0 is loaded with the address being
    // presented; entry RD_LAT lines up with its returning data.
    logic [RD_LAT:0]           dl_vld;
    logic [RD_LAT:0][AWID-1:0] dl_addr;
    logic [RD_LAT:0][DWID-1:0] dl_exp;

    ram2p_bist_pat #(.AWID(AWID), .DWID(DWID)) u_wpat (
        .addr    (waddr_d),
        .pattern (pat_d),
        .data    (wdat_d)
    );

    ram2p_bist_pat #(.AWID(AWID), .DWID(DWID)) u_epat (
        .addr    (raddr_d),
        .pattern (pat_d),
        .data    (exp_d)
    );

    // An abort edge discards whatever was in flight, including the
    // compare that would otherwise land on that edge.
    assign cmp = dl_vld[RD_LAT] && !(o_busy && i_abort);

    always_comb begin
        st_d    = st_q;
        pat_d   = pat_q;
        fl_d    = fl_q;
        busy_d  = o_busy;
        done_d  = o_done;
        we_d    = 1'b0;
        waddr_d = o_waddr;
        raddr_d = o_raddr;
        err_d   = o_err_cnt;
        first_d = o_first_err_addr;
        issue   = 1'b0;
        flush   = 1'b0;

        if (cmp && (i_rdat != dl_exp[RD_LAT])) begin
            if (o_err_cnt == '0) first_d = dl_addr[RD_LAT];
            if (o_err_cnt != ERR_MAX) err_d = o_err_cnt + (AWID+1)'(1);
        end

        if (st_q != IDLE && i_abort) begin
            st_d   = IDLE;
            busy_d = 1'b0;
            flush  = 1'b1;
        end else begin
            unique case (st_q)
                IDLE: begin
                    if (i_start) begin
                        st_d    = FILL;
                        pat_d   = i_pattern;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = '0;
                        first_d = '0;
                        we_d    = 1'b1;
                        waddr_d = '0;
                    end
                end
                FILL: begin
                    if (o_waddr == LAST) begin
                        st_d    = READ;
                        raddr_d = '0;
                        issue   = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = o_waddr + AWID'(1);
                    end
                end
                READ: begin
                    if (o_raddr == LAST) begin
                        st_d = FLUSH;
                        fl_d = '0;
                    end else begin
                        raddr_d = o_raddr + AWID'(1);
                        issue   = 1'b1;
                    end
                end
                FLUSH: begin
                    if (fl_q == FL_LAST) begin
                        st_d   = IDLE;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        fl_d = fl_q + 3'd1;
                    end
                end
            endcase
        end

        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q             <= IDLE;
            pat_q            <= '0;
            fl_q             <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_pass           <= 1'b0;
            o_err_cnt        <= '0;
            o_first_err_addr <= '0;
            o_we             <= 1'b0;
            o_waddr          <= '0;
            o_wdat           <= '0;
            o_raddr          <= '0;
        end else begin
            st_q             <= st_d;
            pat_q            <= pat_d;
            fl_q             <= fl_d;
            o_busy           <= busy_d;
            o_done           <= done_d;
            o_pass           <= pass_d;
            o_err_cnt        <= err_d;
            o_first_err_addr <= first_d;
            o_we             <= we_d;
            o_waddr          <= waddr_d;
            o_wdat           <= wdat_d;
            o_raddr          <= raddr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_vld  <= '0;
            dl_addr <= '0;
            dl_exp  <= '0;
        end else begin
            dl_vld  <= flush ? '0 : {dl_vld[RD_LAT-1:0], issue};
            dl_addr <= {dl_addr[RD_LAT-1:0], raddr_d};
            dl_exp  <= {dl_exp[RD_LAT-1:0], exp_d};
        end
    end

endmodule

// File: tb/tb_ram2p_bist.sv
// Bench for ram2p_bist: attached RAM model with injectable read faults,
// cycle-level reference model, directed and random runs.
module tb_ram2p_bist;

    localparam int AWID    = 8;
    localparam int DWID    = 16;
    localparam int RD_LAT  = 1;
    localparam int DEPTH   = 256;
    localparam int RUN_LEN = 2 * DEPTH + RD_LAT + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_start = 1'b0;
    logic            i_abort = 1'b0;
    logic [1:0]      i_pattern = 2'd0;
    logic            o_busy, o_done, o_pass, o_we;
    logic [AWID:0]   o_err_cnt;
    logic [AWID-1:0] o_first_err_addr, o_waddr, o_raddr;
    logic [DWID-1:0] o_wdat, i_rdat;

    logic [DWID-1:0] mem [DEPTH];
    logic [DWID-1:0] ram_q = '0;
    int fmode = 0;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    ram2p_bist #(.AWID(AWID), .DWID(DWID), .RD_LAT(RD_LAT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .i_pattern        (i_pattern),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_pass           (o_pass),
        .o_err_cnt        (o_err_cnt),
        .o_first_err_addr (o_first_err_addr),
        .o_we             (o_we),
        .o_waddr          (o_waddr),
        .o_wdat           (o_wdat),
        .o_raddr          (o_raddr),
        .i_rdat           (i_rdat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ram2p: write port A, registered read port B
    always @(posedge clk) begin
        if (o_we) mem[o_waddr] <= o_wdat;
        ram_q <= mem[o_raddr];
    end

    function automatic logic [15:0] patv(input logic [1:0] p, input int a);
        case (p)
            2'd0:    return 16'(a);
            2'd1:    return ~16'(a);
            2'd2:    return (a % 2 == 0) ? 16'h5555 : 16'hAAAA;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [15:0] flt(input int m, input logic [15:0] v);
        if (m == 1) return v | 16'h0008;
        if (m == 2) return 16'h0000;
        return v;
    endfunction

    assign i_rdat = flt(fmode, ram_q);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: m_t counts edges since the accepted start edge.
    logic       m_active = 1'b0;
    logic       m_done = 1'b0;
    logic [1:0] m_pat = 2'd0;
    int         m_t = 0;
    int         m_err = 0;
    int         m_first = 0;

    always @(posedge clk or negedge rst_n) begin
        int n;
        if (!rst_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_t      = 0;
            m_err    = 0;
            m_first  = 0;
        end else if (m_active) begin
            if (i_abort) begin
                m_active = 1'b0;
            end else begin
                m_t++;
                n = m_t - DEPTH - RD_LAT - 1;
                if (n >= 0 && n < DEPTH &&
                    flt(fmode, patv(m_pat, n)) != patv(m_pat, n)) begin
                    if (m_err == 0) m_first = n;
                    if (m_err < 2 * DEPTH - 1) m_err++;
                end
                if (m_t == RUN_LEN) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end else if (i_start) begin
            m_active = 1'b1;
            m_t      = 0;
            m_pat    = i_pattern;
            m_done   = 1'b0;
            m_err    = 0;
            m_first  = 0;
        end
    end

    always @(negedge clk) begin
        logic we_x;
        if (rst_n) begin
            we_x = m_active && (m_t < DEPTH);
            chk("busy", 32'(o_busy), 32'(m_active));
            chk("we", 32'(o_we), 32'(we_x));
            if (we_x) begin
                chk("waddr", 32'(o_waddr), 32'(m_t));
                chk("wdat", 32'(o_wdat), 32'(patv(m_pat, m_t)));
            end
            if (m_active && m_t >= DEPTH && m_t < 2 * DEPTH)
                chk("raddr", 32'(o_raddr), 32'(m_t - DEPTH));
            chk("done", 32'(o_done), 32'(m_done));
            chk("pass", 32'(o_pass), 32'(m_done && m_err == 0));
            chk("err_cnt", 32'(o_err_cnt), 32'(m_err));
            chk("first_err", 32'(o_first_err_addr), 32'(m_first));
        end
    end

    task automatic check_zero(input string tag);
        logic [31:0] v;
        v = 32'({o_busy, o_done, o_pass, o_we, o_err_cnt,
                 o_first_err_addr, o_waddr, o_raddr});
        chk({tag, "_ctl"}, v, 32'd0);
        chk({tag, "_wdat"}, 32'(o_wdat), 32'd0);
    endtask

    task automatic do_start(input logic [1:0] p, input logic ab,
                            output int s);
        @(negedge clk);
        i_pattern = p;
        i_start   = 1'b1;
        i_abort   = ab;
        @(posedge clk);
        #1 s = cyc;
        @(negedge clk);
        i_start = 1'b0;
        i_abort = 1'b0;
    endtask

    task automatic at_edge(input int s, input int e);
        while (cyc < s + e - 1) @(negedge clk);
    endtask

    task automatic wait_done(input int s);
        int k;
        k = 0;
        while (!o_done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) chk("done_timeout", 32'(k), 32'd0);
        chk("done_edge", 32'(cyc - s), 32'(RUN_LEN));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        fmode = 0;
        do_start(2'd0, 1'b0, s);
        chk("busy_edge0", 32'(o_busy), 32'd1);
        wait_done(s);
        chk("p0_pass", 32'(o_pass), 32'd1);
        chk("p0_word2a", 32'(mem[8'h2A]), 32'h002A);

        do_start(2'd1, 1'b0, s);
        wait_done(s);
        chk("p1_pass", 32'(o_pass), 32'd1);
        chk("p1_word2a", 32'(mem[8'h2A]), 32'hFFD5);

        do_start(2'd2, 1'b1, s);
        wait_done(s);
        chk("p2_pass", 32'(o_pass), 32'd1);
        chk("p2_word00", 32'(mem[8'h00]), 32'h5555);
        chk("p2_word01", 32'(mem[8'h01]), 32'hAAAA);

        fmode = 1;
        do_start(2'd0, 1'b0, s);
        wait_done(s);
        fmode = 0;
        chk("bit3_err", 32'(o_err_cnt), 32'd128);
        chk("bit3_first", 32'(o_first_err_addr), 32'd0);
        chk("bit3_pass", 32'(o_pass), 32'd0);
        chk("bit3_done", 32'(o_done), 32'd1);

        fmode = 2;
        do_start(2'd3, 1'b0, s);
        wait_done(s);
        fmode = 0;
        chk("zero_err", 32'(o_err_cnt), 32'h100);
        chk("zero_first", 32'(o_first_err_addr), 32'd0);

        do_start(2'd0, 1'b0, s);
        at_edge(s, 100);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort_we", 32'(o_we), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        repeat (3) @(negedge clk);
        do_start(2'd0, 1'b0, s);
        wait_done(s);
        chk("post_abort_pass", 32'(o_pass), 32'd1);

        do_start(2'd1, 1'b0, s);
        at_edge(s, 50);
        i_start   = 1'b1;
        i_pattern = 2'd3;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(s);
        chk("restart_pass", 32'(o_pass), 32'd1);

        do_start(2'd2, 1'b0, s);
        at_edge(s, 300);
        #2 rst_n = 1'b0;
        #1 check_zero("midread_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_idle_busy", 32'(o_busy), 32'd0);

        for (int r = 0; r < 5; r++) begin
            logic [1:0] p;
            int ab;
            p     = 2'($urandom_range(0, 3));
            fmode = $urandom_range(0, 2);
            do_start(p, 1'b0, s);
            if ($urandom_range(0, 1) == 1) begin
                ab = $urandom_range(1, RUN_LEN - 1);
                at_edge(s, ab);
                i_abort = 1'b1;
                @(negedge clk);
                i_abort = 1'b0;
                chk("rnd_abort_busy", 32'(o_busy), 32'd0);
            end else begin
                wait_done(s);
            end
            fmode = 0;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
